// File: rtl/ov_cap_pkg.sv
// Shared definitions for the OV7670 capture engine: input format codes,
// capture state encodings and RGB565 field positions.
package ov_cap_pkg;

   localparam logic FMT_RGB565 = 1'b0;
   localparam logic FMT_YUV422 = 1'b1;

   localparam logic [1:0] WAIT_VS = 2'd0;
   localparam logic [1:0] VS_HIGH = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;

   // MSB of each colour field inside a 16-bit RGB565 pixel
   localparam int R_MSB = 15;
   localparam int G_MSB = 10;
   localparam int B_MSB = 4;

endpackage

// File: rtl/ov_cap_pixel_pack.sv
// Byte-pair assembly for the OV7670 DVP bus. Tracks the byte phase, latches the
// high byte and presents the completed pixel, converted to the RAM word format,
// combinationally on the second byte of each pair.
module ov_cap_pixel_pack
   import ov_cap_pkg::*;
#(
   parameter int OUT_W = 12
)
(
   input  logic             pclk,
   input  logic             reset,
   input  logic             href_cap,
   input  logic             clear,
   input  logic [7:0]       D_data,
   input  logic             fmt,
   output logic             phase,
   output logic             pix_valid,
   output logic [OUT_W-1:0] pix_data
);

   logic [7:0] hi_byte;

   // RGB565 -> RGB444 truncation, RGB565 pass-through, or luma -> grey replication
   function automatic logic [OUT_W-1:0] convert_pixel(input logic [15:0] p, input logic f);
      logic [15:0] w;
      logic [7:0]  y;
      y = p[15:8];
      if (f == FMT_YUV422) begin
         if (OUT_W == 16) w = {y[7:3], y[7:2], y[7:3]};
         else             w = {4'h0, y[7:4], y[7:4], y[7:4]};
      end else begin
         if (OUT_W == 16) w = p;
         else             w = {4'h0, p[R_MSB -: 4], p[G_MSB -: 4], p[B_MSB -: 4]};
      end
      return w[OUT_W-1:0];
   endfunction

   // byte phase toggles on every qualified byte and restarts at each line/frame boundary
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset)        phase <= 1'b0;
      else if (clear)    phase <= 1'b0;
      else if (href_cap) phase <= ~phase;
   end

   // first byte of each pair is held until the second one arrives
   always_ff @(posedge pclk) begin
      if (href_cap && !phase) hi_byte <= D_data;
   end

   assign pix_valid = href_cap && phase;
   assign pix_data  = convert_pixel({hi_byte, D_data}, fmt);

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 DVP capture engine: frame/line tracking, optional 2:1 decimation,
// linear frame-buffer addressing and malformed line/frame flags.
// Optional build macro OV_CAPTURE_STATS_EN adds last_line_px, last_frame_lines
// and frame_cnt statistics outputs.
module ov7670_capture_ctrl
   import ov_cap_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int DECIM    = 2,
   parameter int OUT_W    = 12,
   parameter int ADDR_W   = 17
)
(
   input  logic              pclk,
   input  logic              reset,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        D_data,
   input  logic              fmt,
   output logic [OUT_W-1:0]  save_data,
   output logic [ADDR_W-1:0] save_address,
   output logic              write_enable,
   output logic              frame_done,
   output logic              frame_short,
   output logic              line_err,
   output logic              overflow
`ifdef OV_CAPTURE_STATS_EN
   ,
   output logic [10:0]       last_line_px,
   output logic [10:0]       last_frame_lines,
   output logic [7:0]        frame_cnt
`endif
);

   localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
   localparam logic [10:0]       V_LIM     = 11'(V_ACTIVE);
   localparam logic [10:0]       CNT_MAX   = 11'h7FF;
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'((H_ACTIVE / DECIM) * (V_ACTIVE / DECIM) - 1);

   logic [1:0]        state;
   logic              fmt_q;
   logic              href_d;
   logic [10:0]       x;
   logic [10:0]       y;
   logic              phase;
   logic              pix_valid;
   logic [OUT_W-1:0]  pix_data;
   logic              in_frame;
   logic              href_cap;
   logic              frame_start;
   logic              frame_end;
   logic              line_close;
   logic              store_sel;
   logic              vld_p0;
   logic [OUT_W-1:0]  data_p0;
   logic [ADDR_W-1:0] addr_cnt;
   logic              addr_full;

   // vsync high while capturing ends the frame immediately, even mid-line
   assign in_frame    = (state == CAPTURE) && !vsync;
   assign href_cap    = href && in_frame;
   assign frame_start = (state == VS_HIGH) && !vsync;
   assign frame_end   = (state == CAPTURE) && vsync;
   assign line_close  = in_frame && href_d && !href;

   assign store_sel = pix_valid && (x < H_LIM) && (y < V_LIM) &&
                      ((DECIM == 1) || (!x[0] && !y[0]));

   ov_cap_pixel_pack #(
      .OUT_W (OUT_W)
   ) u_pack (
      .pclk      (pclk),
      .reset     (reset),
      .href_cap  (href_cap),
      .clear     (line_close || !in_frame),
      .D_data    (D_data),
      .fmt       (fmt_q),
      .phase     (phase),
      .pix_valid (pix_valid),
      .pix_data  (pix_data)
   );

   // frame state machine; a reset mid-frame waits for the next full vsync cycle
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         state <= WAIT_VS;
      end else begin
         case (state)
            WAIT_VS: if (vsync)  state <= VS_HIGH;
            VS_HIGH: if (!vsync) state <= CAPTURE;
            CAPTURE: if (vsync)  state <= VS_HIGH;
            default:             state <= WAIT_VS;
         endcase
      end
   end

   // format is fixed for the whole frame at the vsync fall
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         fmt_q  <= FMT_RGB565;
         href_d <= 1'b0;
      end else begin
         href_d <= href;
         if (frame_start) fmt_q <= fmt;
      end
   end

   // x counts completed pixels in the line, y counts closed lines; both saturate
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         x <= '0;
         y <= '0;
      end else if (frame_start) begin
         x <= '0;
         y <= '0;
      end else if (line_close) begin
         x <= '0;
         if (y != CNT_MAX) y <= y + 11'd1;
      end else if (pix_valid && (x != CNT_MAX)) begin
         x <= x + 11'd1;
      end
   end

   // stage p0: selected pixel registered one edge after its second byte
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) vld_p0 <= 1'b0;
      else        vld_p0 <= store_sel;
   end

   // pixel data for stage p0 carries no reset
   always_ff @(posedge pclk) begin
      if (pix_valid) data_p0 <= pix_data;
   end

   // stage p1: RAM write port; the address sticks at the last slot instead of wrapping
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         write_enable <= 1'b0;
         save_data    <= '0;
         save_address <= '0;
         addr_cnt     <= '0;
         addr_full    <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         write_enable <= 1'b0;
         if (frame_start) begin
            addr_cnt  <= '0;
            addr_full <= 1'b0;
            overflow  <= 1'b0;
         end else if (vld_p0) begin
            if (addr_full) begin
               overflow <= 1'b1;
            end else begin
               write_enable <= 1'b1;
               save_data    <= data_p0;
               save_address <= addr_cnt;
               if (addr_cnt == ADDR_LAST) addr_full <= 1'b1;
               else                       addr_cnt  <= addr_cnt + ADDR_W'(1);
            end
         end
      end
   end

   // geometry flags: line_err follows a bad line close, frame_short is latched at frame close
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         line_err    <= 1'b0;
         frame_done  <= 1'b0;
         frame_short <= 1'b0;
      end else begin
         line_err   <= line_close && (phase || (x != H_LIM));
         frame_done <= frame_end;
         if (frame_end) frame_short <= (y < V_LIM);
      end
   end

`ifdef OV_CAPTURE_STATS_EN
   // capture statistics for the most recent line and frame
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         last_line_px     <= '0;
         last_frame_lines <= '0;
         frame_cnt        <= '0;
      end else begin
         if (line_close) last_line_px <= x;
         if (frame_end) begin
            last_frame_lines <= y;
            frame_cnt        <= frame_cnt + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Directed bench for ov7670_capture_ctrl. Three instances share one camera bus:
// d1 (8x4, DECIM=1, RGB444), d2 (8x4, DECIM=2, RGB565) and ov (8x5, DECIM=2,
// 8-word buffer, so the third stored row overflows).
module tb_ov7670_capture_ctrl;

   logic       pclk = 1'b0;
   logic       reset;
   logic       vsync;
   logic       href;
   logic [7:0] D_data;
   logic       fmt;

   logic [11:0] d1_data;  logic [4:0] d1_addr;
   logic        d1_we, d1_fd, d1_fs, d1_le, d1_ov;
   logic [15:0] d2_data;  logic [2:0] d2_addr;
   logic        d2_we, d2_fd, d2_fs, d2_le, d2_ov;
   logic [11:0] ov_data;  logic [2:0] ov_addr;
   logic        ov_we, ov_fd, ov_fs, ov_le, ov_ov;
`ifdef OV_CAPTURE_STATS_EN
   logic [10:0] d1_llp, d1_lfl, d2_llp, d2_lfl, ov_llp, ov_lfl;
   logic [7:0]  d1_fc, d2_fc, ov_fc;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int b2_cyc = -1;

   int wc1 = 0, le1 = 0, fd1 = 0;  logic fs1 = 1'b0;
   int wa1 [64];  int wd1 [64];  int wcy1 [64];
   int wc2 = 0, le2 = 0, fd2 = 0;  logic fs2 = 1'b0;
   int wa2 [64];  int wd2 [64];
   int wc3 = 0, le3 = 0, fd3 = 0;  logic fs3 = 1'b0;
   int la3 = 0, ld3 = 0;

   ov7670_capture_ctrl #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(1), .OUT_W(12), .ADDR_W(5)) u_d1 (
      .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .D_data(D_data), .fmt(fmt),
      .save_data(d1_data), .save_address(d1_addr), .write_enable(d1_we), .frame_done(d1_fd),
      .frame_short(d1_fs), .line_err(d1_le), .overflow(d1_ov)
`ifdef OV_CAPTURE_STATS_EN
      , .last_line_px(d1_llp), .last_frame_lines(d1_lfl), .frame_cnt(d1_fc)
`endif
   );

   ov7670_capture_ctrl #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(2), .OUT_W(16), .ADDR_W(3)) u_d2 (
      .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .D_data(D_data), .fmt(fmt),
      .save_data(d2_data), .save_address(d2_addr), .write_enable(d2_we), .frame_done(d2_fd),
      .frame_short(d2_fs), .line_err(d2_le), .overflow(d2_ov)
`ifdef OV_CAPTURE_STATS_EN
      , .last_line_px(d2_llp), .last_frame_lines(d2_lfl), .frame_cnt(d2_fc)
`endif
   );

   ov7670_capture_ctrl #(.H_ACTIVE(8), .V_ACTIVE(5), .DECIM(2), .OUT_W(12), .ADDR_W(3)) u_ov (
      .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .D_data(D_data), .fmt(fmt),
      .save_data(ov_data), .save_address(ov_addr), .write_enable(ov_we), .frame_done(ov_fd),
      .frame_short(ov_fs), .line_err(ov_le), .overflow(ov_ov)
`ifdef OV_CAPTURE_STATS_EN
      , .last_line_px(ov_llp), .last_frame_lines(ov_lfl), .frame_cnt(ov_fc)
`endif
   );

   always #5 pclk = ~pclk;

   // count rising edges for latency measurement
   always @(posedge pclk) cyc <= cyc + 1;

   // log d1 writes, line errors and frame closes
   always @(negedge pclk) begin
      if (d1_we) begin
         wa1[wc1 % 64]  <= int'(d1_addr);
         wd1[wc1 % 64]  <= int'(d1_data);
         wcy1[wc1 % 64] <= cyc;
         wc1 <= wc1 + 1;
      end
      if (d1_le) le1 <= le1 + 1;
      if (d1_fd) begin fd1 <= fd1 + 1; fs1 <= d1_fs; end
   end

   // log d2 writes, line errors and frame closes
   always @(negedge pclk) begin
      if (d2_we) begin
         wa2[wc2 % 64] <= int'(d2_addr);
         wd2[wc2 % 64] <= int'(d2_data);
         wc2 <= wc2 + 1;
      end
      if (d2_le) le2 <= le2 + 1;
      if (d2_fd) begin fd2 <= fd2 + 1; fs2 <= d2_fs; end
   end

   // log ov writes, line errors and frame closes
   always @(negedge pclk) begin
      if (ov_we) begin
         la3 <= int'(ov_addr);
         ld3 <= int'(ov_data);
         wc3 <= wc3 + 1;
      end
      if (ov_le) le3 <= le3 + 1;
      if (ov_fd) begin fd3 <= fd3 + 1; fs3 <= ov_fs; end
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
      for (int i = 0; i < nbytes; i++) begin
         href   = 1'b1;
         D_data = (i % 2 == 0) ? b0 : b1;
         if (i == 1 && b2_cyc < 0) b2_cyc = cyc + 1;
         @(negedge pclk);
      end
      href   = 1'b0;
      D_data = 8'h00;
      repeat (4) @(negedge pclk);
   endtask

   task automatic frame_start();
      vsync = 1'b1;
      repeat (3) @(negedge pclk);
      vsync = 1'b0;
      repeat (3) @(negedge pclk);
   endtask

   task automatic frame_end();
      vsync = 1'b1;
      repeat (3) @(negedge pclk);
   endtask

   task automatic check_d1_run(input string tag, input int base, input int n, input int addr0, input int data);
      for (int k = 0; k < n; k++) begin
         check({tag, " addr"}, wa1[(base + k) % 64], addr0 + k);
         check({tag, " data"}, wd1[(base + k) % 64], data);
      end
   endtask

   task automatic check_d2_run(input string tag, input int base, input int n, input int data);
      for (int k = 0; k < n; k++) begin
         check({tag, " addr"}, wa2[(base + k) % 64], k);
         check({tag, " data"}, wd2[(base + k) % 64], data);
      end
   endtask

   initial begin
      int b1, b2, b3, l1, s1;
      reset = 1'b0; vsync = 1'b0; href = 1'b0; D_data = 8'h00; fmt = 1'b0;
      repeat (3) @(negedge pclk);
      check("rst we",    int'(d1_we),   0);
      check("rst addr",  int'(d1_addr), 0);
      check("rst data",  int'(d1_data), 0);
      check("rst fd",    int'(d1_fd),   0);
      check("rst le",    int'(d1_le),   0);
      check("rst ovf",   int'(d1_ov),   0);
      reset = 1'b1;
      @(negedge pclk);

      // frame aborted by reset in the middle of line 2, right after a completed pixel
      frame_start();
      send_line(16, 8'hF8, 8'h1F);
      send_line(16, 8'hF8, 8'h1F);
      for (int i = 0; i < 4; i++) begin
         href = 1'b1; D_data = (i % 2 == 0) ? 8'hF8 : 8'h1F;
         @(negedge pclk);
      end
      reset = 1'b0; href = 1'b0;
      @(negedge pclk);
      check("midrst we",   int'(d1_we),   0);
      check("midrst addr", int'(d1_addr), 0);
      check("midrst data", int'(d1_data), 0);
      @(negedge pclk);
      reset = 1'b1;
      @(negedge pclk);
      check("abort d1 writes", wc1, 17);
      check("abort d2 writes", wc2, 5);
      send_line(16, 8'hF8, 8'h1F);
      frame_end();
      check("abort d1 no more writes", wc1, 17);
      check("abort d1 no frame_done", fd1, 0);

      // frame A: RGB565 0xF81F, 4 full lines
      b2_cyc = -1; b1 = wc1; b2 = wc2; b3 = wc3;
      frame_start();
      send_line(16, 8'hF8, 8'h1F);
      check("d2 line0 writes", wc2 - b2, 4);
      send_line(16, 8'hF8, 8'h1F);
      check("d2 odd line writes", wc2 - b2, 4);
      send_line(16, 8'hF8, 8'h1F);
      check("d2 line2 writes", wc2 - b2, 8);
      send_line(16, 8'hF8, 8'h1F);
      frame_end();
      check("A d1 writes", wc1 - b1, 32);
      check_d1_run("A d1", b1, 32, 0, 'hF0F);
      check("A d1 latency", wcy1[b1 % 64], b2_cyc + 1);
      check("A d1 frame_done", fd1, 1);
      check("A d1 frame_short", int'(fs1), 0);
      check("A d1 line_err", le1, 0);
      check("A d1 addr hold", int'(d1_addr), 31);
      check("A d1 data hold", int'(d1_data), 'hF0F);
      check("A d2 writes", wc2 - b2, 8);
      check_d2_run("A d2", b2, 8, 'hF81F);
      check("A d2 frame_short", int'(fs2), 0);
      check("A ov writes", wc3 - b3, 8);
      check("A ov frame_short", int'(fs3), 1);
      check("A ov overflow", int'(ov_ov), 0);

      // frame B: YUYV, Y=0xA5 stored as grey
      fmt = 1'b1; b1 = wc1; b2 = wc2;
      frame_start();
      for (int l = 0; l < 4; l++) send_line(16, 8'hA5, 8'h80);
      frame_end();
      fmt = 1'b0;
      check("B d1 writes", wc1 - b1, 32);
      check("B d1 first data", wd1[b1 % 64], 'hAAA);
      check("B d1 last data", wd1[(b1 + 31) % 64], 'hAAA);
      check("B d2 writes", wc2 - b2, 8);
      check("B d2 first data", wd2[b2 % 64], 'hA534);
      check("B d2 last data", wd2[(b2 + 7) % 64], 'hA534);

      // frame C: 15-byte line, 18-byte line, then two good lines
      b1 = wc1; l1 = le1;
      frame_start();
      send_line(15, 8'hF8, 8'h1F);
      check("C odd line writes", wc1 - b1, 7);
      check("C odd line line_err", le1 - l1, 1);
      s1 = wc1;
      send_line(18, 8'hF8, 8'h1F);
      check("C long line writes", wc1 - s1, 8);
      check("C long line line_err", le1 - l1, 2);
      check("C long line first addr", wa1[s1 % 64], 7);
      check("C long line last addr", wa1[(s1 + 7) % 64], 14);
      send_line(16, 8'hF8, 8'h1F);
      send_line(16, 8'hF8, 8'h1F);
      frame_end();
      check("C good lines line_err", le1 - l1, 2);
      check("C d1 total writes", wc1 - b1, 31);
      check("C d1 frame_short", int'(fs1), 0);

      // frame C2: five lines; d1 ignores the fifth, ov runs out of buffer
      b1 = wc1; b3 = wc3;
      frame_start();
      for (int l = 0; l < 5; l++) send_line(16, 8'hF8, 8'h1F);
      frame_end();
      check("C2 d1 writes", wc1 - b1, 32);
      check("C2 d1 overflow", int'(d1_ov), 0);
      check("C2 ov writes", wc3 - b3, 8);
      check("C2 ov last addr", la3, 7);
      check("C2 ov last data", ld3, 'hF0F);
      check("C2 ov overflow", int'(ov_ov), 1);
      check("C2 ov frame_short", int'(fs3), 0);

      // frame D: vsync after two lines
      b1 = wc1; b3 = wc3;
      frame_start();
      check("D ov overflow cleared", int'(ov_ov), 0);
      send_line(16, 8'hF8, 8'h1F);
      send_line(16, 8'hF8, 8'h1F);
      frame_end();
      check("D d1 writes", wc1 - b1, 16);
      check_d1_run("D d1", b1, 2, 0, 'hF0F);
      check("D d1 frame_done", fd1, 5);
      check("D d1 frame_short", int'(fs1), 1);
      check("D d2 frame_done", fd2, 5);
      check("D d2 frame_short", int'(fs2), 1);
      check("D ov writes", wc3 - b3, 4);
      check("D ov last addr", la3, 3);
      check("D ov frame_done", fd3, 5);
      check("D d2 line_err", le2, 2);
      check("D ov line_err", le3, 2);
      check("D d2 overflow", int'(d2_ov), 0);
`ifdef OV_CAPTURE_STATS_EN
      check("stats d1 frame_cnt", int'(d1_fc), 5);
      check("stats d1 last_frame_lines", int'(d1_lfl), 2);
      check("stats d1 last_line_px", int'(d1_llp), 8);
      check("stats d2 frame_cnt", int'(d2_fc), 5);
      check("stats d2 last_frame_lines", int'(d2_lfl), 2);
      check("stats d2 last_line_px", int'(d2_llp), 8);
      check("stats ov frame_cnt", int'(ov_fc), 5);
      check("stats ov last_frame_lines", int'(ov_lfl), 2);
      check("stats ov last_line_px", int'(ov_llp), 8);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
